// File: rtl/eth_pkt_gen.sv
// eth_pkt_gen: Ethernet test-frame generator on a 64-bit Avalon-ST TX port.
// Optional build macro ETH_PKT_GEN_ERR_INJ_EN enables first-frame error inject.
module eth_pkt_gen #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [47:0]       gen_dst_addr,
  input  logic [47:0]       gen_src_addr,
  input  logic [31:0]       gen_pkt_number,
  input  logic [10:0]       gen_pkt_length,
  input  logic [9:0]        gen_pkt_delay,
  input  logic [31:0]       gen_pkt_ctrl,
  output logic [31:0]       gen_pkt_stat,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [2:0]        tx_empty,
  output logic              tx_error,
  input  logic              tx_ready
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [47:0] dst_r;
  logic [47:0] src_r;
  logic [31:0] num_r;
  logic [10:0] len_r;
  logic [9:0]  dly_r;
  logic [9:0]  gcnt;
  logic [7:0]  wcnt;
  logic [31:0] sent;
  logic        done_r;
  logic        stop_pend;

  logic        start;
  logic        stop;
  logic        go;
  logic        acc;
  logic        eop;
  logic        last;
  logic [10:0] len_eff;
  logic [7:0]  last_w;
  logic [29:0] cnt30;
  logic [15:0] len_fld;
  logic [7:0]  hdr [16];
  logic [63:0] word;
  logic [10:0] bidx;

  assign start = gen_pkt_ctrl[0];
  assign stop  = gen_pkt_ctrl[1];
  assign go    = (state == IDLE) && start && !stop;

  assign len_eff =
    (gen_pkt_length < 11'd60)   ? 11'd60 :
    (gen_pkt_length > 11'd1514) ? 11'd1514 :
    gen_pkt_length;

  assign last_w = 8'((len_r - 11'd1) >> 3);
  assign eop    = (wcnt == last_w);
  assign acc    = (state == SEND) && tx_ready;
  assign last   = (num_r != 32'd0) && (sent + 32'd1 == num_r);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (go) state_nxt = SEND;
      end
      SEND: begin
        if (acc && eop) begin
          if (last || stop_pend || stop) state_nxt = IDLE;
          else if (dly_r != 10'd0)       state_nxt = GAP;
          else                           state_nxt = SEND;
        end
      end
      GAP: begin
        if (stop)                  state_nxt = IDLE;
        else if (gcnt == 10'd1)    state_nxt = SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_r     <= '0;
      src_r     <= '0;
      num_r     <= '0;
      len_r     <= 11'd60;
      dly_r     <= '0;
      gcnt      <= '0;
      wcnt      <= '0;
      sent      <= '0;
      done_r    <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      if (go) begin
        dst_r     <= gen_dst_addr;
        src_r     <= gen_src_addr;
        num_r     <= gen_pkt_number;
        len_r     <= len_eff;
        dly_r     <= gen_pkt_delay;
        wcnt      <= '0;
        sent      <= '0;
        done_r    <= 1'b0;
        stop_pend <= 1'b0;
      end
      if (state == SEND && stop) stop_pend <= 1'b1;
      if (acc) begin
        wcnt <= eop ? 8'd0 : wcnt + 8'd1;
        if (eop && sent != '1) sent <= sent + 32'd1;
      end
      // gap counter loads on entry and runs down to 1
      if (state_nxt == GAP && state != GAP) gcnt <= dly_r;
      else if (state == GAP)                gcnt <= gcnt - 10'd1;
      if (state != IDLE && state_nxt == IDLE) done_r <= 1'b1;
    end
  end

  assign len_fld = {5'd0, len_r} - 16'd14;

  always_comb begin
    for (int j = 0; j < 6; j++) begin
      hdr[j]     = dst_r[47-8*j -: 8];
      hdr[j + 6] = src_r[47-8*j -: 8];
    end
    hdr[12] = len_fld[15:8];
    hdr[13] = len_fld[7:0];
    hdr[14] = 8'h00;
    hdr[15] = 8'h00;
  end

  // bytes past the frame length stay zero as padding
  always_comb begin
    word = '0;
    bidx = '0;
    for (int k = 0; k < 8; k++) begin
      bidx = {wcnt, 3'(k)};
      if (bidx < len_r) begin
        if (bidx < 11'd14) word[63-8*k -: 8] = hdr[bidx[3:0]];
        else               word[63-8*k -: 8] = 8'(bidx - 11'd14);
      end
    end
  end

  assign tx_valid = (state == SEND);
  assign tx_data  = tx_valid ? word : '0;
  assign tx_sop   = tx_valid && (wcnt == 8'd0);
  assign tx_eop   = tx_valid && eop;
  assign tx_empty = tx_eop ? (3'd0 - len_r[2:0]) : 3'd0;

  assign cnt30 = (|sent[31:30]) ? {30{1'b1}} : sent[29:0];
  assign gen_pkt_stat = {state != IDLE, done_r, cnt30};

`ifdef ETH_PKT_GEN_ERR_INJ_EN
  logic err_r;
  logic unused_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   err_r <= 1'b0;
    else if (go) err_r <= gen_pkt_ctrl[3];
  end

  assign tx_error    = tx_eop && err_r && (sent == 32'd0);
  assign unused_ctrl = ^{gen_pkt_ctrl[31:4], gen_pkt_ctrl[2]};
`else
  logic unused_ctrl;

  assign tx_error    = 1'b0;
  assign unused_ctrl = ^gen_pkt_ctrl[31:2];
`endif

endmodule

// File: tb/tb_eth_pkt_gen.sv
// tb_eth_pkt_gen: directed checks of eth_pkt_gen frames, gaps, stop, reset.
// Expected words come from a byte-level frame model inside the bench.
module tb_eth_pkt_gen;

  logic        clk;
  logic        reset;
  logic [47:0] gen_dst_addr;
  logic [47:0] gen_src_addr;
  logic [31:0] gen_pkt_number;
  logic [10:0] gen_pkt_length;
  logic [9:0]  gen_pkt_delay;
  logic [31:0] gen_pkt_ctrl;
  logic [31:0] gen_pkt_stat;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_sop;
  logic        tx_eop;
  logic [2:0]  tx_empty;
  logic        tx_error;
  logic        tx_ready;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic [47:0] cfg_dst;
  logic [47:0] cfg_src;
  logic [63:0] wq [$];

`ifdef ETH_PKT_GEN_ERR_INJ_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  eth_pkt_gen #(.DATA_W(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .gen_dst_addr   (gen_dst_addr),
    .gen_src_addr   (gen_src_addr),
    .gen_pkt_number (gen_pkt_number),
    .gen_pkt_length (gen_pkt_length),
    .gen_pkt_delay  (gen_pkt_delay),
    .gen_pkt_ctrl   (gen_pkt_ctrl),
    .gen_pkt_stat   (gen_pkt_stat),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_sop         (tx_sop),
    .tx_eop         (tx_eop),
    .tx_empty       (tx_empty),
    .tx_error       (tx_error),
    .tx_ready       (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int l, input int w);
    logic [63:0] r;
    logic [15:0] lf;
    logic [7:0]  b;
    int i;
    r  = '0;
    lf = 16'(l - 14);
    for (int k = 0; k < 8; k++) begin
      i = w * 8 + k;
      if (i >= l)       b = 8'h00;
      else if (i < 6)   b = cfg_dst[47-8*i -: 8];
      else if (i < 12)  b = cfg_src[47-8*(i-6) -: 8];
      else if (i == 12) b = lf[15:8];
      else if (i == 13) b = lf[7:0];
      else              b = 8'(i - 14);
      r[63-8*k -: 8] = b;
    end
    return r;
  endfunction

  task automatic cfg(input logic [47:0] d, input logic [47:0] s,
                     input int n, input int l, input int g);
    cfg_dst        = d;
    cfg_src        = s;
    gen_dst_addr   = d;
    gen_src_addr   = s;
    gen_pkt_number = 32'(n);
    gen_pkt_length = 11'(l);
    gen_pkt_delay  = 10'(g);
  endtask

  task automatic send_start(input logic [31:0] c, output int ts);
    @(negedge clk);
    ts = cyc;
    gen_pkt_ctrl = c;
    @(negedge clk);
    gen_pkt_ctrl = 32'h0;
  endtask

  // Receive one frame starting at the current negedge.
  task automatic rx_frame(input int l, input bit rnd, input bit eerr,
                          input int p_at, input logic [31:0] p_val,
                          output int t_sop, output int t_eop,
                          output int nw);
    int idx;
    int wn;
    bit seen;
    bit hold;
    bit pulsed;
    logic [63:0] pd;
    logic [5:0]  pf;
    idx = 0; seen = 0; hold = 0; pulsed = 0;
    pd = '0; pf = '0;
    t_sop = -1; t_eop = -1; nw = 0;
    wn = (l + 7) / 8;
    wq.delete();
    for (int c = 0; c < 4000; c++) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      gen_pkt_ctrl = 32'h0;
      if (seen) chk("no_bubble", tx_valid, 1);
      if (!seen && tx_valid) begin
        seen  = 1;
        t_sop = cyc;
      end
      if (seen && tx_valid) begin
        if (hold) begin
          chk("hold_data", tx_data, pd);
          chk("hold_flags", {tx_sop, tx_eop, tx_empty, tx_error}, pf);
        end else begin
          chk("data", tx_data, exp_word(l, idx));
          chk("sop", tx_sop, idx == 0);
          chk("eop", tx_eop, idx == wn - 1);
          chk("err", tx_error, (idx == wn - 1) ? eerr : 1'b0);
          if (idx == wn - 1)
            chk("empty", tx_empty, (8 - l % 8) % 8);
        end
        if (!pulsed && idx == p_at) begin
          gen_pkt_ctrl = p_val;
          pulsed = 1;
        end
        pd = tx_data;
        pf = {tx_sop, tx_eop, tx_empty, tx_error};
        hold = !tx_ready;
        if (tx_ready) begin
          wq.push_back(tx_data);
          idx++;
          nw++;
          if (idx == wn) begin
            t_eop = cyc;
            return;
          end
        end
      end
      @(negedge clk);
    end
    chk("frame_timeout", 1, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ts, s1, e1, s2, e2, s3, e3, nw;
    reset = 1'b1;
    tx_ready = 1'b0;
    gen_pkt_ctrl = 32'h0;
    cfg(48'h0, 48'h0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_stat", gen_pkt_stat, 32'h0);
    chk("rst_valid", {tx_valid, tx_sop, tx_eop, tx_error}, 4'h0);
    chk("rst_data", tx_data, 64'h0);
    chk("rst_empty", tx_empty, 3'd0);
    reset = 1'b0;

    // single frame, plus start+stop together ignored
    cfg(48'h001122334455, 48'h66778899AABB, 1, 64, 0);
    @(negedge clk);
    gen_pkt_ctrl = 32'h3;
    @(negedge clk);
    gen_pkt_ctrl = 32'h0;
    chk("startstop_valid", tx_valid, 0);
    chk("startstop_stat", gen_pkt_stat, 32'h0);
    send_start(32'h1, ts);
    rx_frame(64, 0, 0, -1, 0, s1, e1, nw);
    chk("t1_latency", s1, ts + 1);
    chk("t1_words", nw, 8);
    chk("t1_w0", wq[0], 64'h0011223344556677);
    chk("t1_w1", wq[1], 64'h8899AABB00320001);
    chk("t1_stat_pre", gen_pkt_stat, 32'h80000000);
    @(negedge clk);
    chk("t1_stat", gen_pkt_stat, 32'h40000001);

    // length clamp low and large frame
    cfg(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 1, 20, 0);
    send_start(32'h1, ts);
    rx_frame(60, 0, 0, -1, 0, s1, e1, nw);
    chk("t2_words60", nw, 8);
    chk("t2_lenfld", wq[1][31:16], 16'h002E);
    @(negedge clk);
    cfg(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 1, 1200, 0);
    send_start(32'h1, ts);
    rx_frame(1200, 0, 0, -1, 0, s1, e1, nw);
    chk("t2_words1200", nw, 150);
    @(negedge clk);
    chk("t2_stat", gen_pkt_stat, 32'h40000001);

    // gap, random backpressure, config writes mid-run ignored
    cfg(48'h0A0B0C0D0E0F, 48'h102030405060, 3, 100, 5);
    send_start(32'h1, ts);
    gen_dst_addr   = '1;
    gen_src_addr   = '1;
    gen_pkt_length = 11'd1514;
    gen_pkt_delay  = 10'd0;
    gen_pkt_number = 32'd1;
    rx_frame(100, 1, 0, -1, 0, s1, e1, nw);
    @(negedge clk);
    rx_frame(100, 1, 0, -1, 0, s2, e2, nw);
    chk("t3_gap1", s2 - e1, 6);
    @(negedge clk);
    rx_frame(100, 1, 0, -1, 0, s3, e3, nw);
    chk("t3_gap2", s3 - e2, 6);
    @(negedge clk);
    chk("t3_stat", gen_pkt_stat, 32'h40000003);

    // continuous mode, start while busy, stop mid-frame
    cfg(48'h112233445566, 48'h778899AABBCC, 0, 64, 0);
    send_start(32'h1, ts);
    rx_frame(64, 0, 0, -1, 0, s1, e1, nw);
    @(negedge clk);
    rx_frame(64, 0, 0, 2, 32'h1, s2, e2, nw);
    chk("t4_b2b1", s2, e1 + 1);
    @(negedge clk);
    rx_frame(64, 0, 0, 3, 32'h2, s3, e3, nw);
    chk("t4_b2b2", s3, e2 + 1);
    @(negedge clk);
    chk("t4_stat", gen_pkt_stat, 32'h40000003);
    repeat (3) @(negedge clk);
    chk("t4_idle", tx_valid, 0);

    // async reset in word 3 of a max frame
    cfg(48'hDEADBEEF0001, 48'hCAFEF00D0002, 1, 1514, 0);
    tx_ready = 1'b1;
    send_start(32'h1, ts);
    repeat (3) @(negedge clk);
    chk("t5_w3", tx_data, exp_word(1514, 3));
    reset = 1'b1;
    #1;
    chk("t5_valid", {tx_valid, tx_sop, tx_eop, tx_error}, 4'h0);
    chk("t5_data", tx_data, 64'h0);
    chk("t5_empty", tx_empty, 3'd0);
    chk("t5_stat", gen_pkt_stat, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cfg(48'hDEADBEEF0001, 48'hCAFEF00D0002, 1, 64, 0);
    send_start(32'h1, ts);
    rx_frame(64, 0, 0, -1, 0, s1, e1, nw);
    chk("t5_latency", s1, ts + 1);
    chk("t5_words", nw, 8);

    // error inject request on ctrl[3]
    @(negedge clk);
    cfg(48'h020406080A0C, 48'h0E1012141618, 2, 64, 0);
    send_start(32'h9, ts);
    rx_frame(64, 0, ERR_ON, -1, 0, s1, e1, nw);
    @(negedge clk);
    rx_frame(64, 0, 0, -1, 0, s2, e2, nw);
    @(negedge clk);
    chk("t6_stat", gen_pkt_stat, 32'h40000002);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
